// File: rtl/manchester_pkg.sv
// Shared constants and FSM encoding for the Manchester-to-NRZ decoder.
package manchester_pkg;

    localparam int OVS_DEFAULT   = 8;
    localparam int EARLY_DEFAULT = 3 * OVS_DEFAULT / 4;
    localparam int LATE_DEFAULT  = 5 * OVS_DEFAULT / 4;

    typedef enum logic [2:0] {
        HUNT  = 3'b001,
        MID   = 3'b010,
        BOUND = 3'b100
    } state_t;

    // Oversampling must give four equal quarter-bit slots and room for jitter.
    function automatic logic legal_ovs(input int ovs);
        return ((ovs % 4) == 0) && (ovs >= 8);
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for the raw line plus a one-cycle transition detector.
module edge_sync (
    input  logic clock,
    input  logic reset,
    input  logic in,
    output logic level,
    output logic edge_s
);

    logic sync1_r;
    logic sync2_r;
    logic dly_r;

    // Metastability chain followed by the delayed copy used for edge detection.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            dly_r   <= 1'b0;
        end else begin
            sync1_r <= in;
            sync2_r <= sync1_r;
            dly_r   <= sync2_r;
        end
    end

    assign level  = sync2_r;
    assign edge_s = sync2_r ^ dly_r;

endmodule

// File: rtl/manchester2nrz.sv
// Manchester line decoder: locks onto mid-bit transitions and emits NRZ bits
// with a one-cycle valid strobe, flagging loss of lock with an err strobe.
module manchester2nrz
    import manchester_pkg::*;
#(
    parameter int OVS   = OVS_DEFAULT,
    parameter int EARLY = 3 * OVS / 4,
    parameter int LATE  = 5 * OVS / 4
) (
    input  logic clock,
    input  logic reset,
    input  logic in,
    output logic out,
    output logic valid,
    output logic err,
    output logic locked
);

    localparam int CW = $clog2(2 * OVS);
    localparam int DW = CW + 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(2 * OVS - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [DW-1:0] EARLY_C  = DW'(EARLY);
    localparam logic [DW-1:0] LATE_C   = DW'(LATE);

    if (!legal_ovs(OVS) || (EARLY < 1) || (EARLY > LATE) || (LATE >= 2 * OVS)) begin : g_bad_params
        $error("manchester2nrz: illegal OVS/EARLY/LATE combination");
    end

    logic          level_s;
    logic          edge_s;
    logic [DW-1:0] dist_s;
    logic          early_s;
    logic          in_win_s;
    logic          late_s;

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic          out_r;
    logic          valid_r;
    logic          err_r;
    logic          locked_r;

    edge_sync u_edge_sync (
        .clock  (clock),
        .reset  (reset),
        .in     (in),
        .level  (level_s),
        .edge_s (edge_s)
    );

    // cnt holds cycles since the last edge minus one, so dist is the true edge spacing.
    always_comb begin
        dist_s   = {1'b0, cnt_r} + DW'(1);
        early_s  = (dist_s < EARLY_C);
        in_win_s = (dist_s >= EARLY_C) && (dist_s <= LATE_C);
        late_s   = (dist_s > LATE_C);
    end

    // Lock FSM with spacing counter and registered decode outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r  <= HUNT;
            cnt_r    <= CNT_ZERO;
            out_r    <= 1'b0;
            valid_r  <= 1'b0;
            err_r    <= 1'b0;
            locked_r <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            err_r   <= 1'b0;
            if (cnt_r != CNT_MAX) begin
                cnt_r <= cnt_r + CNT_ONE;
            end
            case (state_r)
                HUNT: begin
                    if (edge_s) begin
                        cnt_r <= CNT_ZERO;
                        if (in_win_s) begin
                            state_r  <= MID;
                            locked_r <= 1'b1;
                            out_r    <= level_s;
                            valid_r  <= 1'b1;
                        end
                    end
                end
                MID, BOUND: begin
                    // A late edge and a timeout coincide at the same distance; both lose lock.
                    if (late_s) begin
                        state_r  <= HUNT;
                        locked_r <= 1'b0;
                        err_r    <= 1'b1;
                        cnt_r    <= CNT_ZERO;
                    end else if (edge_s) begin
                        if (!early_s) begin
                            state_r <= MID;
                            out_r   <= level_s;
                            valid_r <= 1'b1;
                            cnt_r   <= CNT_ZERO;
                        end else if (state_r == MID) begin
                            state_r <= BOUND;
                        end else begin
                            state_r  <= HUNT;
                            locked_r <= 1'b0;
                            err_r    <= 1'b1;
                            cnt_r    <= CNT_ZERO;
                        end
                    end
                end
                default: begin
                    state_r  <= HUNT;
                    locked_r <= 1'b0;
                    cnt_r    <= CNT_ZERO;
                end
            endcase
        end
    end

    assign out    = out_r;
    assign valid  = valid_r;
    assign err    = err_r;
    assign locked = locked_r;

endmodule

// File: tb/tb_manchester2nrz.sv
// Directed bench for manchester2nrz at OVS=8: lock, framing, jitter limits,
// timeout, glitch recovery and asynchronous reset.
module tb_manchester2nrz;

    logic clock = 1'b0;
    logic reset;
    logic in;
    logic out;
    logic valid;
    logic err;
    logic locked;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   errs     = 0;
    int   unlock   = 0;
    int   both     = 0;
    int   outchg   = 0;
    logic prev_out = 1'b0;
    logic vq[$];
    int   tq[$];

    manchester2nrz #(.OVS(8)) dut (
        .clock  (clock),
        .reset  (reset),
        .in     (in),
        .out    (out),
        .valid  (valid),
        .err    (err),
        .locked (locked)
    );

    always #5 clock = ~clock;

    // Observe outputs 1 time unit after each rising edge.
    always @(posedge clock) begin
        #1;
        cyc++;
        if (valid === 1'b1) begin
            vq.push_back(out);
            tq.push_back(cyc);
        end
        if (err === 1'b1) errs++;
        if (valid === 1'b1 && err === 1'b1) both++;
        if (locked !== 1'b1) unlock++;
        if (out !== prev_out && valid !== 1'b1 && reset === 1'b1) outchg++;
        prev_out = out;
    end

    task automatic clear_mon();
        vq.delete();
        tq.delete();
        errs   = 0;
        unlock = 0;
    endtask

    task automatic drive(input logic lvl, input int n);
        in = lvl;
        repeat (n) @(negedge clock);
    endtask

    task automatic toggle(input int n);
        in = ~in;
        repeat (n) @(negedge clock);
    endtask

    task automatic send_bit(input logic b);
        drive(~b, 4);
        drive(b, 4);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        in    = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (out !== 1'b0)    begin failures++; $display("FAIL reset_out got=%b exp=0", out); end
        checks++; if (valid !== 1'b0)  begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (err !== 1'b0)    begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b exp=0", locked); end
        reset = 1'b1;
        @(posedge clock);
        #1;
        checks++; if (valid !== 1'b0 || err !== 1'b0) begin
            failures++; $display("FAIL release_pulse got valid=%b err=%b exp 0/0", valid, err);
        end
        @(negedge clock);
    endtask

    task automatic test_preamble();
        clear_mon();
        drive(1'b0, 20);
        for (int i = 0; i < 16; i++) send_bit((i % 2) == 0);
        checks++; if (vq.size() != 15) begin failures++; $display("FAIL pre_count got=%0d exp=15", vq.size()); end
        for (int k = 0; k < vq.size(); k++) begin
            checks++; if (vq[k] !== ((k % 2) == 1)) begin
                failures++; $display("FAIL pre_bit%0d got=%b exp=%b", k, vq[k], (k % 2) == 1);
            end
            if (k > 0) begin
                checks++; if (tq[k] - tq[k-1] != 8) begin
                    failures++; $display("FAIL pre_gap%0d got=%0d exp=8", k, tq[k] - tq[k-1]);
                end
            end
        end
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL pre_locked got=%b exp=1", locked); end
        checks++; if (errs != 0) begin failures++; $display("FAIL pre_err got=%0d exp=0", errs); end
    endtask

    task automatic test_frame();
        logic [7:0] frame;
        frame = 8'h5A;
        clear_mon();
        for (int i = 7; i >= 0; i--) send_bit(frame[i]);
        checks++; if (vq.size() != 8) begin failures++; $display("FAIL frame_count got=%0d exp=8", vq.size()); end
        for (int k = 0; k < 8 && k < vq.size(); k++) begin
            checks++; if (vq[k] !== frame[7-k]) begin
                failures++; $display("FAIL frame_bit%0d got=%b exp=%b", k, vq[k], frame[7-k]);
            end
        end
        checks++; if (errs != 0) begin failures++; $display("FAIL frame_err got=%0d exp=0", errs); end
    endtask

    task automatic test_timeout();
        clear_mon();
        drive(in, 20);
        checks++; if (errs != 1) begin failures++; $display("FAIL timeout_err got=%0d exp=1", errs); end
        checks++; if (vq.size() != 0) begin failures++; $display("FAIL timeout_valid got=%0d exp=0", vq.size()); end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL timeout_locked got=%b exp=0", locked); end
    endtask

    task automatic test_jitter();
        int gaps[4] = '{6, 10, 6, 10};
        clear_mon();
        toggle(8);
        toggle(6);
        toggle(10);
        toggle(6);
        toggle(10);
        toggle(5);
        checks++; if (vq.size() != 5) begin failures++; $display("FAIL jit_count got=%0d exp=5", vq.size()); end
        for (int k = 0; k < 5 && k < vq.size(); k++) begin
            checks++; if (vq[k] !== ((k % 2) == 1)) begin
                failures++; $display("FAIL jit_bit%0d got=%b exp=%b", k, vq[k], (k % 2) == 1);
            end
            if (k > 0) begin
                checks++; if (tq[k] - tq[k-1] != gaps[k-1]) begin
                    failures++; $display("FAIL jit_gap%0d got=%0d exp=%0d", k, tq[k] - tq[k-1], gaps[k-1]);
                end
            end
        end
        checks++; if (errs != 0) begin failures++; $display("FAIL jit_err got=%0d exp=0", errs); end
        // Spacing 5 after a mid-bit edge.
        clear_mon();
        toggle(20);
        checks++; if (errs != 1) begin failures++; $display("FAIL sp5_err got=%0d exp=1", errs); end
        checks++; if (vq.size() != 0) begin failures++; $display("FAIL sp5_valid got=%0d exp=0", vq.size()); end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL sp5_locked got=%b exp=0", locked); end
        // Re-lock with one bit, then spacing 11.
        clear_mon();
        toggle(8);
        toggle(11);
        toggle(20);
        checks++; if (errs != 1) begin failures++; $display("FAIL sp11_err got=%0d exp=1", errs); end
        checks++; if (vq.size() != 1) begin failures++; $display("FAIL sp11_valid got=%0d exp=1", vq.size()); end
        if (vq.size() > 0) begin
            checks++; if (vq[0] !== 1'b1) begin failures++; $display("FAIL sp11_bit got=%b exp=1", vq[0]); end
        end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL sp11_locked got=%b exp=0", locked); end
    endtask

    task automatic test_glitch();
        clear_mon();
        for (int i = 0; i < 6; i++) send_bit((i % 2) == 0);
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL gl_prelock got=%b exp=1", locked); end
        clear_mon();
        drive(1'b0, 4);
        drive(1'b1, 1);
        drive(1'b0, 1);
        drive(1'b1, 2);
        for (int i = 0; i < 8; i++) send_bit((i % 2) == 1);
        checks++; if (errs != 1) begin failures++; $display("FAIL gl_err got=%0d exp=1", errs); end
        checks++; if (unlock == 0) begin failures++; $display("FAIL gl_hunt got=%0d unlocked cycles exp>0", unlock); end
        checks++; if (vq.size() != 9) begin failures++; $display("FAIL gl_count got=%0d exp=9", vq.size()); end
        for (int k = 0; k < 9 && k < vq.size(); k++) begin
            checks++; if (vq[k] !== ((k % 2) == 0)) begin
                failures++; $display("FAIL gl_bit%0d got=%b exp=%b", k, vq[k], (k % 2) == 0);
            end
        end
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL gl_relock got=%b exp=1", locked); end
    endtask

    task automatic test_reset_mid();
        checks++; if (out !== 1'b1) begin failures++; $display("FAIL rm_pre_out got=%b exp=1", out); end
        drive(1'b1, 2);
        #2;
        reset = 1'b0;
        #1;
        checks++; if (out !== 1'b0)    begin failures++; $display("FAIL rm_out got=%b exp=0", out); end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL rm_locked got=%b exp=0", locked); end
        checks++; if (valid !== 1'b0 || err !== 1'b0) begin
            failures++; $display("FAIL rm_pulse got valid=%b err=%b exp 0/0", valid, err);
        end
        @(negedge clock);
        repeat (2) @(negedge clock);
        clear_mon();
        reset = 1'b1;
        @(posedge clock);
        #1;
        checks++; if (valid !== 1'b0 || err !== 1'b0) begin
            failures++; $display("FAIL rm_release got valid=%b err=%b exp 0/0", valid, err);
        end
        @(negedge clock);
        drive(1'b0, 20);
        for (int i = 0; i < 16; i++) send_bit((i % 2) == 0);
        checks++; if (errs != 0) begin failures++; $display("FAIL rm_err got=%0d exp=0", errs); end
        checks++; if (vq.size() != 15) begin failures++; $display("FAIL rm_count got=%0d exp=15", vq.size()); end
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL rm_locked_after got=%b exp=1", locked); end
    endtask

    task automatic test_invariants();
        checks++; if (both != 0) begin failures++; $display("FAIL valid_err_overlap got=%0d exp=0", both); end
        checks++; if (outchg != 0) begin failures++; $display("FAIL out_hold got=%0d changes exp=0", outchg); end
    endtask

    initial begin
        test_reset();
        test_preamble();
        test_frame();
        test_timeout();
        test_jitter();
        test_glitch();
        test_reset_mid();
        test_invariants();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
